lfsr_share_arbiter: RTL
=======================

LFSR_SHARE_ARBITER -- requirements
Module: lfsr_share_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_DRAWS, default 8, the maximum number of LFSR draws per grant before declaring failure (legal range 1-15).
REQ-002 The block SHALL have port Clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port Req, input, 4 bits: one level request per screen requester, held until Done or abandoned.
REQ-005 The block SHALL have port Excl_Mask, input, 16 bits: bits [4i+3:4i] mark the 2-bit values that requester i rejects (bit v set means value v is rejected).
REQ-006 The block SHALL have port Random, input, 2 bits: the current output of the shared lfsr_rng.
REQ-007 The block SHALL have port Pulse, output, 1 bit: registered advance strobe to lfsr_rng.
REQ-008 The block SHALL have port Grant, output, 4 bits: one-hot (or zero) registered grant.
REQ-009 The block SHALL have port Rnd_Out, output, 2 bits: the accepted value, held until the next accept.
REQ-010 The block SHALL have port Done, output, 1 bit: one-cycle completion strobe for the granted requester.
REQ-011 The block SHALL have port Fail, output, 1 bit: qualifies Done; high means no acceptable value was found.
REQ-012 The block SHALL have port Busy, output, 1 bit: high in every state except IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, DRAW, SETTLE, RELEASE.
REQ-014 In IDLE with Req != 0, the block SHALL select the first set Req bit at or after round-robin pointer Ptr (wrapping 3->0), set Grant to that one-hot value, clear the draw counter, and go to DRAW.
REQ-015 In IDLE with Req == 0, the block SHALL stay in IDLE.
REQ-016 The block SHALL drive Pulse high during exactly the DRAW cycle and low in all other states; DRAW SHALL always go to SETTLE, incrementing the draw counter.
REQ-017 In SETTLE, if Random's bit in the winner's Excl_Mask nibble is clear, the block SHALL load Rnd_Out <= Random, pulse Done with Fail=0, and go to RELEASE.
REQ-018 In SETTLE, if Random is rejected and the draw count < MAX_DRAWS, the block SHALL return to DRAW; if the draw count == MAX_DRAWS, it SHALL pulse Done with Fail=1, leave Rnd_Out unchanged, and go to RELEASE.
REQ-019 If the winner's mask nibble is 4'b1111 on entry to SETTLE, the block SHALL fail immediately without further draws.
REQ-020 In RELEASE, the block SHALL clear Grant, Done and Fail, set Ptr to winner+1 mod 4, and go to IDLE.
REQ-021 Latency: with Req sampled at edge k and the first value accepted, Grant and Pulse SHALL be high after k, and Done after k+2; each extra draw SHALL add 2 cycles.
REQ-022 If the granted Req bit drops in DRAW or SETTLE, the block SHALL go to RELEASE without Done and with Rnd_Out unchanged; Ptr still advances.
REQ-023 Requests arriving while Busy SHALL wait; requests from other requesters SHALL NOT change the current Grant.
REQ-024 If Req stays high after Done, the block SHALL treat it as a new request subject to round-robin order.

Reset
REQ-025 Rst high SHALL asynchronously force state IDLE, Ptr=0, draw counter=0, and Pulse, Grant, Rnd_Out, Done, Fail, Busy = 0.
REQ-026 Reset mid-transaction SHALL abandon the transaction with no Done; service restarts from requester 0.

Structure
REQ-027 State encodings and the requester count (4) SHALL live in the shared project include file.
REQ-028 The round-robin selection SHALL be a combinational sub-module rr_pick4 (Req, Ptr -> one-hot winner, valid).
REQ-029 lfsr_rng SHALL be instantiated outside this block; this block only drives Pulse and reads Random.

Verification
REQ-030 The bench SHALL check: Req=4'b0001, mask 0, Random=2 -> Grant=0001, one Pulse, Done after 3 edges, Rnd_Out=2, Fail=0.
REQ-031 The bench SHALL check: Req=4'b1111 held -> Grants in order 0001, 0010, 0100, 1000, 0001.
REQ-032 The bench SHALL check: requester 1 mask 4'b0011, Random sequence 0,1,3 -> three Pulses, Rnd_Out=3, Done at cycle 7.
REQ-033 The bench SHALL check: mask 4'b1110, Random stuck at 3, MAX_DRAWS=8 -> 8 Pulses, then Done=1, Fail=1, Rnd_Out unchanged.
REQ-034 The bench SHALL check: mask 4'b1111 -> Done=1, Fail=1 two edges after Grant, one Pulse only.
REQ-035 The bench SHALL check: Req drop in SETTLE, and separately Rst asserted in DRAW -> no Done, outputs at reset/idle values, Ptr advanced (drop) or 0 (reset).

Source files
------------

// File: rtl/lfsr_share_arbiter_pkg.sv
// Shared definitions for the LFSR share arbiter.
// Holds the requester count, the FSM state encodings and a one-hot to index helper.
package lfsr_share_arbiter_pkg;

  localparam int unsigned NumReq = 4;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StDraw    = 2'd1;
  localparam logic [1:0] StSettle  = 2'd2;
  localparam logic [1:0] StRelease = 2'd3;

  // Index of the set bit of a one-hot requester vector (0 when empty).
  function automatic logic [1:0] onehot_idx(input logic [NumReq-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NumReq; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/lfsr_share_arbiter_rr_pick4.sv
// Combinational four-way round-robin picker.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - highest-priority requester index for this pick
//   grant_o - one-hot winner (zero when no request)
//   valid_o - any request present
module rr_pick4
  import lfsr_share_arbiter_pkg::*;
(
  input  logic [NumReq-1:0] req_i,
  input  logic [1:0]        ptr_i,
  output logic [NumReq-1:0] grant_o,
  output logic              valid_o
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    grant_o = '0;
    valid_o = |req_i;
    idx     = 2'd0;
    found   = 1'b0;
    // Scan from ptr_i upward; the 2-bit index wraps 3 -> 0 naturally.
    for (int i = 0; i < NumReq; i++) begin
      idx = ptr_i + 2'(i);
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lfsr_share_arbiter.sv
// Arbitrates four requesters for a shared random source. The winner gets repeated
// draws from an external RNG (advanced by Pulse) until a value outside its exclusion
// mask appears, or the draw budget runs out.
// Ports:
//   Clk, Rst  - clock, asynchronous active-high reset
//   Req       - level requests, one per requester
//   Excl_Mask - per-requester nibble of rejected 2-bit values
//   Random    - current RNG output
//   Pulse     - registered RNG advance strobe (high in the DRAW cycle)
//   Grant     - registered one-hot grant
//   Rnd_Out   - last accepted value
//   Done/Fail - one-cycle completion strobe, Fail qualifies it
//   Busy      - FSM not idle
module lfsr_share_arbiter
  import lfsr_share_arbiter_pkg::*;
#(
  parameter int unsigned MAX_DRAWS = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [NumReq-1:0]    Req,
  input  logic [4*NumReq-1:0]  Excl_Mask,
  input  logic [1:0]           Random,
  output logic                 Pulse,
  output logic [NumReq-1:0]    Grant,
  output logic [1:0]           Rnd_Out,
  output logic                 Done,
  output logic                 Fail,
  output logic                 Busy
);

  localparam logic [3:0] MaxDraws = 4'(MAX_DRAWS);

  logic [1:0]        state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [1:0]        win_q, win_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              pulse_q, pulse_d;
  logic [NumReq-1:0] grant_q, grant_d;
  logic [1:0]        rnd_q, rnd_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;

  logic [NumReq-1:0] pick_grant;
  logic              pick_valid;
  logic [3:0]        nibble;
  logic              rejected;
  logic              req_held;

  rr_pick4 u_pick (
    .req_i   (Req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .valid_o (pick_valid)
  );

  assign nibble   = Excl_Mask[{win_q, 2'b00} +: 4];
  assign rejected = nibble[Random];
  assign req_held = Req[win_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    rnd_d   = rnd_q;
    pulse_d = 1'b0;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          win_d   = onehot_idx(pick_grant);
          cnt_d   = 4'd0;
          pulse_d = 1'b1;
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (!req_held) begin
          state_d = StRelease;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (!req_held) begin
          // Abandoned: no completion strobe, accepted value untouched.
          state_d = StRelease;
        end else if (nibble == 4'hF) begin
          done_d  = 1'b1;
          fail_d  = 1'b1;
          state_d = StRelease;
        end else if (!rejected) begin
          rnd_d   = Random;
          done_d  = 1'b1;
          state_d = StRelease;
        end else if (cnt_q < MaxDraws) begin
          pulse_d = 1'b1;
          state_d = StDraw;
        end else begin
          done_d  = 1'b1;
          fail_d  = 1'b1;
          state_d = StRelease;
        end
      end
      default: begin // StRelease
        grant_d = '0;
        ptr_d   = win_q + 2'd1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      win_q   <= 2'd0;
      cnt_q   <= 4'd0;
      pulse_q <= 1'b0;
      grant_q <= '0;
      rnd_q   <= 2'd0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      grant_q <= grant_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign Pulse   = pulse_q;
  assign Grant   = grant_q;
  assign Rnd_Out = rnd_q;
  assign Done    = done_q;
  assign Fail    = fail_q;
  assign Busy    = (state_q != StIdle);

endmodule
